// File: rtl/taxi_i2c_target_regs_if.sv
// Bus bundle between an I2C target register block and its surroundings.
// Latency: n/a (wires only).
// Backpressure: only when TAXI_I2C_TARGET_CLK_STRETCH_EN is defined (rd_ready).
//
// master modport: line levels and read data into the target; target outputs back.
// slave modport : the target itself.
// Macro TAXI_I2C_TARGET_CLK_STRETCH_EN adds the rd_ready signal.
interface taxi_i2c_target_regs_if #(
    parameter int REG_CNT = 16
);
    localparam int PTR_W = $clog2(REG_CNT);

    logic             scl_i;
    logic             sda_i;
    logic             scl_o;
    logic             sda_o;
    logic             wr_valid;
    logic [PTR_W-1:0] wr_addr;
    logic [7:0]       wr_data;
    logic [PTR_W-1:0] rd_addr;
    logic [7:0]       rd_data;
    logic             busy;
`ifdef TAXI_I2C_TARGET_CLK_STRETCH_EN
    logic             rd_ready;

    modport master (
        output scl_i, sda_i, rd_data, rd_ready,
        input  scl_o, sda_o, wr_valid, wr_addr, wr_data, rd_addr, busy
    );
    modport slave (
        input  scl_i, sda_i, rd_data, rd_ready,
        output scl_o, sda_o, wr_valid, wr_addr, wr_data, rd_addr, busy
    );
`else
    modport master (
        output scl_i, sda_i, rd_data,
        input  scl_o, sda_o, wr_valid, wr_addr, wr_data, rd_addr, busy
    );
    modport slave (
        input  scl_i, sda_i, rd_data,
        output scl_o, sda_o, wr_valid, wr_addr, wr_data, rd_addr, busy
    );
`endif
endinterface

// File: rtl/taxi_i2c_target_regs.sv
// I2C target exposing a REG_CNT-entry register window (pointer byte, then data bytes).
// Latency: sda_o reacts about FILTER_LEN+3 clk cycles after a bus SCL fall.
// Backpressure: none by default; with TAXI_I2C_TARGET_CLK_STRETCH_EN, SCL is held low until rd_ready.
//
// Ports: clk, rst_n (async, active-low); bus (slave modport):
//   scl_i/sda_i line levels, scl_o/sda_o open-drain drive (1 = release),
//   wr_valid/wr_addr/wr_data write strobe, rd_addr/rd_data read fabric, busy.
// Optional feature macro: TAXI_I2C_TARGET_CLK_STRETCH_EN (adds bus.rd_ready).
module taxi_i2c_target_regs #(
    parameter logic [6:0] DEV_ADDR   = 7'h50,
    parameter int         REG_CNT    = 16,
    parameter int         FILTER_LEN = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    taxi_i2c_target_regs_if.slave bus
);
    localparam int PTR_W  = $clog2(REG_CNT);
    localparam int FCNT_W = $clog2(FILTER_LEN + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
        S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK, S_WAIT_STOP
    } state_t;

    // Input conditioning: index 0 = SCL, index 1 = SDA.
    logic [1:0]        w_raw;
    logic [1:0]        r_sync_a, r_sync_b, r_filt, r_filt_d;
    logic [FCNT_W-1:0] r_fcnt [2];

    assign w_raw = {bus.sda_i, bus.scl_i};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync_a <= '1;
            r_sync_b <= '1;
            r_filt   <= '1;
            r_filt_d <= '1;
            r_fcnt[0] <= '0;
            r_fcnt[1] <= '0;
        end else begin
            r_sync_a <= w_raw;
            r_sync_b <= r_sync_a;
            r_filt_d <= r_filt;
            // A new level is accepted only after FILTER_LEN consecutive cycles.
            for (int i = 0; i < 2; i++) begin
                if (r_sync_b[i] == r_filt[i]) begin
                    r_fcnt[i] <= '0;
                end else if (r_fcnt[i] == FCNT_W'(FILTER_LEN - 1)) begin
                    r_filt[i] <= r_sync_b[i];
                    r_fcnt[i] <= '0;
                end else begin
                    r_fcnt[i] <= r_fcnt[i] + 1'b1;
                end
            end
        end
    end

    logic w_scl, w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;
    assign w_scl      = r_filt[0];
    assign w_sda      = r_filt[1];
    assign w_scl_rise = w_scl & ~r_filt_d[0];
    assign w_scl_fall = ~w_scl & r_filt_d[0];
    assign w_start    = w_scl & r_filt_d[0] & r_filt_d[1] & ~w_sda;
    assign w_stop     = w_scl & r_filt_d[0] & ~r_filt_d[1] & w_sda;

    state_t           r_state, w_state_nxt;
    logic [3:0]       r_bit_cnt, w_bit_cnt_nxt;
    logic [7:0]       r_shift, w_shift_nxt;
    logic [7:0]       r_tx, w_tx_nxt;
    logic             r_sda_o, w_sda_o_nxt;
    logic [PTR_W-1:0] r_ptr, w_ptr_nxt;
    logic             r_wr_valid, w_wr_valid_nxt;
    logic [PTR_W-1:0] r_wr_addr, w_wr_addr_nxt;
    logic [7:0]       r_wr_data, w_wr_data_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_rw, w_rw_nxt;
    logic             r_mack, w_mack_nxt;
    logic             w_rd_start;
`ifdef TAXI_I2C_TARGET_CLK_STRETCH_EN
    logic             r_scl_o, w_scl_o_nxt;
    logic             r_stretch, w_stretch_nxt;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_tx       <= '0;
            r_sda_o    <= 1'b1;
            r_ptr      <= '0;
            r_wr_valid <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_busy     <= 1'b0;
            r_rw       <= 1'b0;
            r_mack     <= 1'b0;
`ifdef TAXI_I2C_TARGET_CLK_STRETCH_EN
            r_scl_o    <= 1'b1;
            r_stretch  <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_shift    <= w_shift_nxt;
            r_tx       <= w_tx_nxt;
            r_sda_o    <= w_sda_o_nxt;
            r_ptr      <= w_ptr_nxt;
            r_wr_valid <= w_wr_valid_nxt;
            r_wr_addr  <= w_wr_addr_nxt;
            r_wr_data  <= w_wr_data_nxt;
            r_busy     <= w_busy_nxt;
            r_rw       <= w_rw_nxt;
            r_mack     <= w_mack_nxt;
`ifdef TAXI_I2C_TARGET_CLK_STRETCH_EN
            r_scl_o    <= w_scl_o_nxt;
            r_stretch  <= w_stretch_nxt;
`endif
        end
    end

    // Bytes are shifted in on SCL rise; a byte completes on the SCL fall that
    // follows its 8th rise, which is also where the ACK drive begins.
    always_comb begin
        w_state_nxt    = r_state;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_shift_nxt    = r_shift;
        w_tx_nxt       = r_tx;
        w_sda_o_nxt    = r_sda_o;
        w_ptr_nxt      = r_ptr;
        w_wr_valid_nxt = 1'b0;
        w_wr_addr_nxt  = r_wr_addr;
        w_wr_data_nxt  = r_wr_data;
        w_busy_nxt     = r_busy;
        w_rw_nxt       = r_rw;
        w_mack_nxt     = r_mack;
        w_rd_start     = 1'b0;
`ifdef TAXI_I2C_TARGET_CLK_STRETCH_EN
        w_scl_o_nxt    = r_scl_o;
        w_stretch_nxt  = r_stretch;
`endif
        if (w_start || w_stop) begin
            // Any partial byte is dropped; both lines are released.
            w_state_nxt   = w_start ? S_ADDR : S_IDLE;
            w_bit_cnt_nxt = '0;
            w_sda_o_nxt   = 1'b1;
            if (w_stop) begin
                w_busy_nxt = 1'b0;
            end
`ifdef TAXI_I2C_TARGET_CLK_STRETCH_EN
            w_scl_o_nxt   = 1'b1;
            w_stretch_nxt = 1'b0;
`endif
        end else begin
            case (r_state)
                S_ADDR, S_PTR, S_WDATA: begin
                    if (w_scl_rise && !r_bit_cnt[3]) begin
                        w_shift_nxt   = {r_shift[6:0], w_sda};
                        w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                    end else if (w_scl_fall && r_bit_cnt[3]) begin
                        w_bit_cnt_nxt = '0;
                        w_sda_o_nxt   = 1'b0;
                        if (r_state == S_ADDR) begin
                            if (r_shift[7:1] == DEV_ADDR) begin
                                w_state_nxt = S_ADDR_ACK;
                                w_rw_nxt    = r_shift[0];
                                w_busy_nxt  = 1'b1;
                            end else begin
                                w_state_nxt = S_WAIT_STOP;
                                w_sda_o_nxt = 1'b1;
                            end
                        end else if (r_state == S_PTR) begin
                            w_state_nxt = S_PTR_ACK;
                            w_ptr_nxt   = r_shift[PTR_W-1:0];
                        end else begin
                            w_state_nxt    = S_WDATA_ACK;
                            w_wr_valid_nxt = 1'b1;
                            w_wr_addr_nxt  = r_ptr;
                            w_wr_data_nxt  = r_shift;
                            w_ptr_nxt      = r_ptr + 1'b1;
                        end
                    end
                end
                S_ADDR_ACK: begin
                    if (w_scl_fall) begin
                        w_sda_o_nxt   = 1'b1;
                        w_bit_cnt_nxt = '0;
                        if (r_rw) begin
                            w_rd_start = 1'b1;
                        end else begin
                            w_state_nxt = S_PTR;
                        end
                    end
                end
                S_PTR_ACK, S_WDATA_ACK: begin
                    if (w_scl_fall) begin
                        w_state_nxt   = S_WDATA;
                        w_sda_o_nxt   = 1'b1;
                        w_bit_cnt_nxt = '0;
                    end
                end
                S_RDATA: begin
`ifdef TAXI_I2C_TARGET_CLK_STRETCH_EN
                    if (r_stretch) begin
                        if (bus.rd_ready) begin
                            w_tx_nxt      = bus.rd_data;
                            w_sda_o_nxt   = bus.rd_data[7];
                            w_scl_o_nxt   = 1'b1;
                            w_stretch_nxt = 1'b0;
                        end
                    end else
`endif
                    if (w_scl_rise && !r_bit_cnt[3]) begin
                        w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                    end else if (w_scl_fall && r_bit_cnt[3]) begin
                        // Release SDA for the controller's ACK; advance pointer now.
                        w_state_nxt   = S_RDATA_ACK;
                        w_sda_o_nxt   = 1'b1;
                        w_bit_cnt_nxt = '0;
                        w_ptr_nxt     = r_ptr + 1'b1;
                    end else if (w_scl_fall) begin
                        w_tx_nxt    = {r_tx[6:0], 1'b0};
                        w_sda_o_nxt = r_tx[6];
                    end
                end
                S_RDATA_ACK: begin
                    if (w_scl_rise) begin
                        w_mack_nxt = ~w_sda;
                    end else if (w_scl_fall) begin
                        if (r_mack) begin
                            w_rd_start = 1'b1;
                        end else begin
                            w_state_nxt = S_WAIT_STOP;
                        end
                    end
                end
                default: ;
            endcase

            // Start of a read byte: rd_data is captured on this SCL-fall cycle.
            if (w_rd_start) begin
                w_state_nxt   = S_RDATA;
                w_bit_cnt_nxt = '0;
`ifdef TAXI_I2C_TARGET_CLK_STRETCH_EN
                if (!bus.rd_ready) begin
                    w_scl_o_nxt   = 1'b0;
                    w_stretch_nxt = 1'b1;
                    w_sda_o_nxt   = 1'b1;
                end else
`endif
                begin
                    w_tx_nxt    = bus.rd_data;
                    w_sda_o_nxt = bus.rd_data[7];
                end
            end
        end
    end

    assign bus.sda_o    = r_sda_o;
    assign bus.wr_valid = r_wr_valid;
    assign bus.wr_addr  = r_wr_addr;
    assign bus.wr_data  = r_wr_data;
    assign bus.rd_addr  = r_ptr;
    assign bus.busy     = r_busy;
`ifdef TAXI_I2C_TARGET_CLK_STRETCH_EN
    assign bus.scl_o    = r_scl_o;
`else
    assign bus.scl_o    = 1'b1;
`endif
endmodule
